inst_fetch: RTL and testbench

- Fetch stage directly upstream of the PC-update stage.
- Owns the fetch PC register, issues word reads to instruction memory over a valid/ready request port, and buffers returned {pc, inst} pairs in a small in-order FIFO.
- Presents each pair to the PC-update stage, which consumes fetch_pc as pc_in and fetch_inst as inst.
- Accepts a branch redirect from that stage, flushes its buffer and discards stale in-flight responses.

---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/inst_fetch_chk.sv | 27 ++
 rtl/inst_fetch.sv | 162 ++++++++++++++++
 tb/tb_inst_fetch.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU constants and types for the fetch stage.
// Provides the reset PC, datapath widths, the PC increment, the fetch FSM
// state type, the buffered {pc, inst} entry type and a PC alignment helper.
package inst_fetch_pkg;

    localparam int          ADDR_WIDTH   = 32;
    localparam int          INST_WIDTH   = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous in-order FIFO of fetched {pc, inst} entries.
// Ports: clk, rst_n (async active-low), flush (empties the FIFO, wins over
// push/pop), push/wr_entry (write tail), pop (release head), rd_entry (head,
// zero when empty), full, empty, count (current occupancy).
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             wr_entry,
    input  logic                     pop,
    output fetch_entry_t             rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW:0]   wr_ptr_q, wr_ptr_d;
    logic [PW:0]   rd_ptr_q, rd_ptr_d;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (count == (PW+1)'(DEPTH));
    assign rd_entry = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

    // Next storage and pointer values; flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = {(PW+1){1'b0}};
            rd_ptr_d = {(PW+1){1'b0}};
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[PW-1:0]] = wr_entry;
                wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= {(PW+1){1'b0}};
            rd_ptr_q <= {(PW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/inst_fetch_chk.sv
// Invariant checker for the fetch stage counters and buffer.
// Ports: clk, rst_n, outstanding/drop_cnt counters, fifo_push/fifo_full.
module inst_fetch_chk #(
    parameter int CW      = 3,
    parameter int MAX_OUT = 4
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop_cnt,
    input logic          fifo_push,
    input logic          fifo_full
);

    // A live response must always find room in the buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full));

    // Issued-but-unreturned requests never exceed the cap.
    a_out_cap: assert property (@(posedge clk) disable iff (!rst_n)
        32'(outstanding) <= 32'(MAX_OUT));

    // Only requests actually in flight can be marked for discard.
    a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt <= outstanding);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to
// instruction memory, buffers returned {pc, inst} pairs and hands them to the
// PC-update stage. A redirect flushes the buffer and discards in-flight data.
// Ports: clk, reset (async active-low); imem_req_* request port;
// imem_rsp_* in-order response port; redirect_valid/redirect_pc from the
// PC-update stage; fetch_valid/ready/pc/inst towards the PC-update stage.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = CPU_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [INST_WIDTH-1:0] fetch_inst
);

    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    // PC of the next live response; stays in step with fpc because responses
    // return in order and a redirect kills every older request.
    logic [ADDR_WIDTH-1:0] rpc_q, rpc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_q, drop_d;

    logic                  issue_ok_s;
    logic                  accept_s;
    logic                  live_rsp_s;
    logic                  stale_rsp_s;
    logic                  fifo_push_s;
    logic                  fifo_pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FCW-1:0]        fifo_count_s;
    logic [CW-1:0]         live_cnt_s;
    fetch_entry_t          fifo_wr_s;
    fetch_entry_t          fifo_rd_s;

    // Buffered entries plus live in-flight requests must fit the FIFO, so a
    // live response can never meet a full buffer.
    assign live_cnt_s  = outstanding_q - drop_q;
    assign issue_ok_s  = (state_q == ST_RUN)
                      && ((32'(fifo_count_s) + 32'(live_cnt_s)) < 32'(FIFO_DEPTH))
                      && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));

    assign imem_req_valid = issue_ok_s && !redirect_valid;
    assign imem_req_addr  = fpc_q;
    assign accept_s       = imem_req_valid && imem_req_ready;

    assign live_rsp_s  = imem_rsp_valid && (drop_q == {CW{1'b0}});
    assign stale_rsp_s = imem_rsp_valid && (drop_q != {CW{1'b0}});
    // A live response colliding with a redirect is itself stale.
    assign fifo_push_s = live_rsp_s && !redirect_valid;
    assign fifo_pop_s  = fetch_valid && fetch_ready;

    assign fifo_wr_s.pc   = rpc_q;
    assign fifo_wr_s.inst = imem_rsp_data;

    assign fetch_valid = !fifo_empty_s;
    assign fetch_pc    = fifo_rd_s.pc;
    assign fetch_inst  = fifo_rd_s.inst;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (redirect_valid),
        .push     (fifo_push_s),
        .wr_entry (fifo_wr_s),
        .pop      (fifo_pop_s),
        .rd_entry (fifo_rd_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    inst_fetch_chk #(
        .CW      (CW),
        .MAX_OUT (MAX_OUTSTANDING)
    ) u_chk (
        .clk         (clk),
        .rst_n       (reset),
        .outstanding (outstanding_q),
        .drop_cnt    (drop_q),
        .fifo_push   (fifo_push_s),
        .fifo_full   (fifo_full_s)
    );

    // Next-state logic: FSM, fetch PC, return PC and request counters.
    always_comb begin
        state_d       = state_q;
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q
                      + {{(CW-1){1'b0}}, accept_s}
                      - {{(CW-1){1'b0}}, imem_rsp_valid};

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase

        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the
            // abandoned path.
            fpc_d  = align_pc(redirect_pc);
            rpc_d  = align_pc(redirect_pc);
            drop_d = outstanding_d;
        end else begin
            if (accept_s) begin
                fpc_d = fpc_q + PC_STEP;
            end else begin
                fpc_d = fpc_q;
            end
            if (live_rsp_s) begin
                rpc_d = rpc_q + PC_STEP;
            end else begin
                rpc_d = rpc_q;
            end
            if (stale_rsp_s) begin
                drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_BOOT;
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            drop_q        <= {CW{1'b0}};
        end else begin
            state_q       <= state_d;
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: an in-order memory model with
// configurable latency, a reference fetch stream (each redirect or reset
// restarts it at the aligned target, stepping by 4) and a monitor comparing
// every consumed {pc, inst} against it.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_min = 1, lat_max = 1;
    int rdy_mode = 0;       // 0: always ready, 1: random
    int frdy_mode = 0;      // 0: always, 1: never, 2: random
    bit pend_redir = 1'b0;
    logic [31:0] pend_tgt = 32'd0;
    int pops_epoch = 0;
    int total_pops = 0;
    int accepts = 0;
    int first_req = -1;
    int first_fv = -1;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic new_epoch(input logic [31:0] t);
        exp_q.delete();
        exp_next   = t & 32'hFFFF_FFFC;
        pops_epoch = 0;
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    // One clock of stimulus: memory response, readies, redirect; then record
    // the request handshake and update the expected stream.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        imem_req_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (frdy_mode == 0)      fetch_ready = 1'b1;
        else if (frdy_mode == 1) fetch_ready = 1'b0;
        else                     fetch_ready = 1'($urandom_range(0, 1));
        redirect_valid = pend_redir;
        redirect_pc    = pend_redir ? pend_tgt : $urandom;
        pend_redir     = 1'b0;
        #1;
        if (imem_req_valid && first_req < 0) first_req = cyc;
        if (fetch_valid && first_fv < 0) first_fv = cyc;
        if (redirect_valid) chk("req_valid_in_redirect", {31'd0, imem_req_valid}, 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
            accepts++;
        end
        #1;
        if (redirect_valid) new_epoch(redirect_pc);
        refill();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        fetch_ready    = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_fetch_inst", fetch_inst, 32'd0);
        mem_q.delete();
        repeat (2) @(negedge clk);
        reset     = 1'b1;
        cyc       = 0;
        first_req = -1;
        first_fv  = -1;
        accepts   = 0;
        new_epoch(32'h0000_0000);
        refill();
        #1;
        chk("boot_no_req", {31'd0, imem_req_valid}, 32'd0);
    endtask

    // Monitor: compares each consumed head against the expected stream and
    // checks the outputs are zero while the buffer is empty.
    always @(negedge clk) begin
        #1;
        if (reset === 1'b1) begin
            if (fetch_valid && fetch_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exp_stream actual=%h required=<none>", fetch_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("fetch_pc", fetch_pc, e);
                    chk("fetch_inst", fetch_inst, inst_of(e));
                    pops_epoch++;
                    total_pops++;
                end
            end else if (!fetch_valid) begin
                chk("empty_pc_zero", fetch_pc, 32'd0);
                chk("empty_inst_zero", fetch_inst, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit found;
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fetch_ready    = 1'b0;
        #2;

        // Boot latency and sequential stream.
        do_reset();
        repeat (12) step();
        chk("first_req_cycle", first_req, 32'd1);
        chk("first_fv_cycle", first_fv, 32'd3);
        chk("boot_progress", {31'd0, pops_epoch >= 5}, 32'd1);

        // Backpressure: buffer fills with 0x0 and 0x4, then issue stops.
        do_reset();
        frdy_mode = 1;
        repeat (10) step();
        chk("bp_fetch_valid", {31'd0, fetch_valid}, 32'd1);
        chk("bp_head_pc", fetch_pc, 32'h0);
        chk("bp_head_inst", fetch_inst, inst_of(32'h0));
        chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("bp_accepts", accepts, 32'd2);
        frdy_mode = 0;
        repeat (15) step();
        chk("bp_resume", {31'd0, pops_epoch >= 6}, 32'd1);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (mem_q.size() == 2) found = 1'b1;
        end
        chk("two_in_flight", {31'd0, found}, 32'd1);
        pend_redir = 1'b1; pend_tgt = 32'h0000_0100;
        step();
        repeat (20) step();
        chk("redir_progress", {31'd0, pops_epoch >= 2}, 32'd1);

        // Redirect coinciding with an arriving response, unaligned target.
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) found = 1'b1;
            else step();
        end
        chk("rsp_collision_found", {31'd0, found}, 32'd1);
        pend_redir = 1'b1; pend_tgt = 32'h0000_0203;
        step();
        chk("collision_rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
        repeat (15) step();
        chk("collision_progress", {31'd0, pops_epoch >= 3}, 32'd1);

        // Wrap-around past the top of the address space.
        pend_redir = 1'b1; pend_tgt = 32'hFFFF_FFF8;
        step();
        repeat (15) step();
        chk("wrap_progress", {31'd0, pops_epoch >= 3}, 32'd1);

        // Reset while two entries are buffered.
        frdy_mode = 1;
        repeat (8) step();
        chk("pre_rst_valid", {31'd0, fetch_valid}, 32'd1);
        do_reset();
        frdy_mode = 0;
        repeat (10) step();
        chk("rerst_first_req", first_req, 32'd1);
        chk("rerst_first_fv", first_fv, 32'd3);

        // Randomized traffic: latency, readies and redirects.
        lat_min = 1; lat_max = 4;
        rdy_mode = 1; frdy_mode = 2;
        total_pops = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                pend_redir = 1'b1;
                pend_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom;
            end
            step();
        end
        chk("random_progress", {31'd0, total_pops > 300}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
